fp_mul_pipe: RTL and testbench

Pipelined IEEE-754 single-precision multiplier that sits directly upstream of the PE floating-point adder and produces the product term of the PE multiply-accumulate. It accepts one operand pair per cycle under a valid/ready handshake and delivers packed FP32 products three cycles later. Arithmetic conventions match the downstream adder:
- truncation, no rounding
- denormals flushed to zero
- a single canonical quiet NaN

---
 rtl/fp_mul_pipe_if.sv | 24 ++
 rtl/fp_mul_pipe.sv | 140 ++++++++++++++
 tb/tb_fp_mul_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/product handshake bundle for fp_mul_pipe
// Ports (signals):
//   in_valid/in_ready/in_a/in_b     operand pair handshake, upstream -> block
//   out_valid/out_ready/out_p       product handshake, block -> downstream
// Modports: master = upstream/downstream side, slave = the multiplier.
interface fp_mul_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage FP32 multiplier, truncating, flush-to-zero
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, clears all stage valids and out_p
//   bus   fp_mul_pipe_if.slave: operands in, packed FP32 product out
// Stages: S1 unpack/classify, S2 24x24 multiply, S3 normalize/pack.
module fp_mul_pipe #(
  parameter int          BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  fp_mul_pipe_if.slave bus
);

  // The whole pipe moves in lockstep; a stalled output freezes every stage,
  // so bubbles are kept rather than collapsed.
  logic w_advance;
  assign w_advance = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_advance;

  // ---------------- S1 combinational: unpack/classify ----------------
  logic [7:0]        w_ea, w_eb;
  logic [22:0]       w_fa, w_fb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic signed [9:0] w_e1;

  assign w_ea = bus.in_a[30:23];
  assign w_eb = bus.in_b[30:23];
  assign w_fa = bus.in_a[22:0];
  assign w_fb = bus.in_b[22:0];

  // Exponent 0 means zero regardless of mantissa: denormals are flushed.
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'h0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'h0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'h0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'h0);

  // 10-bit signed covers -127..383, the full range of ea+eb-bias.
  assign w_e1 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(10'(BIAS));

  logic              r_s1_valid, r_s1_sign, r_s1_nan, r_s1_inf, r_s1_zero;
  logic signed [9:0] r_s1_e;
  logic [23:0]       r_s1_ma, r_s1_mb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_e     <= '0;
      r_s1_ma    <= '0;
      r_s1_mb    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= bus.in_valid;
      r_s1_sign  <= bus.in_a[31] ^ bus.in_b[31];
      r_s1_nan   <= w_a_nan || w_b_nan;
      r_s1_inf   <= w_a_inf || w_b_inf;
      r_s1_zero  <= w_a_zero || w_b_zero;
      r_s1_e     <= w_e1;
      r_s1_ma    <= {1'b1, w_fa};
      r_s1_mb    <= {1'b1, w_fb};
    end
  end

  // ---------------- S2: multiply ----------------
  logic              r_s2_valid, r_s2_sign, r_s2_nan, r_s2_inf, r_s2_zero;
  logic signed [9:0] r_s2_e;
  logic [47:0]       r_s2_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_nan   <= 1'b0;
      r_s2_inf   <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_e     <= '0;
      r_s2_p     <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_nan   <= r_s1_nan;
      r_s2_inf   <= r_s1_inf;
      r_s2_zero  <= r_s1_zero;
      r_s2_e     <= r_s1_e;
      r_s2_p     <= 48'(r_s1_ma) * 48'(r_s1_mb);
    end
  end

  // ---------------- S3 combinational: normalize/pack ----------------
  // Product of two [1,2) mantissas lies in [1,4): at most one shift needed.
  logic              w_norm;
  logic [22:0]       w_mant;
  logic signed [9:0] w_e3;
  logic [31:0]       w_pack;
  logic              w_unused;

  assign w_norm   = r_s2_p[47];
  assign w_mant   = w_norm ? r_s2_p[46:24] : r_s2_p[45:23];
  assign w_e3     = w_norm ? (r_s2_e + 10'sd1) : r_s2_e;
  // Truncated low product bits carry no information forward.
  assign w_unused = ^r_s2_p[22:0];

  always_comb begin
    w_pack = {r_s2_sign, w_e3[7:0], w_mant};
    if (r_s2_nan || (r_s2_inf && r_s2_zero)) begin
      w_pack = QNAN;
    end else if (r_s2_inf) begin
      w_pack = {r_s2_sign, 8'hFF, 23'h0};
    end else if (r_s2_zero) begin
      w_pack = {r_s2_sign, 31'h0};
    end else if (w_e3 >= 10'sd255) begin
      w_pack = {r_s2_sign, 8'hFF, 23'h0};
    end else if (w_e3 <= 10'sd0) begin
      w_pack = {r_s2_sign, 31'h0};
    end
  end

  logic        r_s3_valid;
  logic [31:0] r_s3_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_s3_p     <= 32'h0;
    end else if (w_advance) begin
      r_s3_valid <= r_s2_valid;
      r_s3_p     <= w_pack;
    end
  end

  assign bus.out_valid = r_s3_valid;
  assign bus.out_p     = r_s3_p;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - scoreboard/vector bench for fp_mul_pipe
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mul_pipe_if bus ();

  fp_mul_pipe #(.BIAS(127), .QNAN(32'h7FC00000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_out  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor: compares every transferred product against the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", bus.out_p, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_out++;
        check("product", bus.out_p, e.p);
        if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
  end

  // Drive one pair starting #1 after a rising edge; returns #1 after accept.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    e.p = p; e.cyc = cyc; e.chk_lat = chk_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  vec_t vecs[10];
  vec_t bp[5];

  initial begin
    int   n;
    logic bad;
    logic [31:0] held;

    vecs[0] = '{32'hC0000000, 32'h40400000, 32'hC0C00000};
    vecs[1] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[2] = '{32'h40400000, 32'h40400000, 32'h41100000};
    vecs[3] = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[4] = '{32'hFF800000, 32'h40000000, 32'hFF800000};
    vecs[5] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[6] = '{32'h00000001, 32'h7F000000, 32'h00000000};
    vecs[7] = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    vecs[8] = '{32'h00800000, 32'h00800000, 32'h00000000};
    vecs[9] = '{32'h80800000, 32'h3F800000, 32'h80800000};

    bp[0] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    bp[1] = '{32'h40000000, 32'h3F800000, 32'h40000000};
    bp[2] = '{32'h40400000, 32'h3F800000, 32'h40400000};
    bp[3] = '{32'h40800000, 32'h3F800000, 32'h40800000};
    bp[4] = '{32'h40A00000, 32'h3F800000, 32'h40A00000};

    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check("reset_out_p", bus.out_p, 32'h0);
    rst = 1'b0;

    // 1. Single op with exact latency, then out_valid drops
    send(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
    drain();
    @(negedge clk);
    check("single_valid_after", {31'h0, bus.out_valid}, 32'd0);

    // 2-4. Streaming table: normal, specials, range limits back to back
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
    drain();

    // 5. Backpressure: 4-cycle stall right after the first output
    n_out = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 5; i++) send(bp[i].a, bp[i].b, bp[i].p, 1'b0);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.out_valid && n < 50);
        check("bp_first_valid", {31'h0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) held = bus.out_p;
          check("bp_in_ready_low", {31'h0, bus.in_ready}, 32'd0);
          check("bp_valid_held", {31'h0, bus.out_valid}, 32'd1);
          check("bp_p_stable", bus.out_p, held);
          if (sb.size() != 0) check("bp_held_value", bus.out_p, sb[0].p);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(n_out), 32'd5);

    // 6. Asynchronous reset with three items in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(32'h40000000, 32'h40000000, 32'h40800000, 1'b0);
    send(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0);
    send(32'h40800000, 32'h40000000, 32'h41000000, 1'b0);
    check("rst_pre_valid", {31'h0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'h0, bus.out_valid}, 32'd0);
    check("rst_async_p", bus.out_p, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) bad = 1'b1;
    end
    check("rst_no_stale_output", {31'h0, bad}, 32'd0);
    @(posedge clk); #1;
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
